digit_serial_addsub: RTL and testbench

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/digit_serial_addsub_digit_adder.sv | 37 +++
 rtl/digit_serial_addsub.sv | 174 +++++++++++++++++
 tb/tb_digit_serial_addsub.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the digit-serial arithmetic blocks: the word FSM
// state encoding and default width parameters.
// ---------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dsa_state_t;

  localparam int DEF_DIGIT_W = 1;
  localparam int DEF_WORD_W  = 32;

endpackage : serial_arith_pkg

// File: rtl/digit_serial_addsub_digit_adder.sv
// ---------------------------------------------------------------------------
// digit_adder
// Combinational W-bit ripple-carry adder.
//   a, b     : W-bit addends
//   cin      : carry into bit 0
//   sum      : W-bit sum
//   cout     : carry out of the MSB
//   msb_cin  : carry into the MSB (used for signed-overflow detection)
// ---------------------------------------------------------------------------
module digit_adder #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);

  logic [W:0] carry;

  // NOTE: every signal written in always_comb is given a value before any
  // conditional or loop, so no latch can be inferred.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    cout    = carry[W];
    msb_cin = carry[W-1];
  end

endmodule : digit_adder

// File: rtl/digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub
// Digit-serial adder/subtractor. Operands arrive LSB-first, DIGIT_W bits per
// cycle; a word is WORD_W/DIGIT_W digits. All outputs are registered, so the
// result digit of an accepted input appears one cycle later.
//
// Ports
//   clk, rst              : clock (rising edge), synchronous active-high reset
//   in_valid              : x_digit/y_digit/in_first/sub valid this cycle
//   in_first              : digit is the LSB digit of a new word
//   sub                   : 0 = X+Y, 1 = X-Y (sampled with in_valid&in_first)
//   x_digit, y_digit      : operand digits
//   out_valid, out_digit  : result digit
//   out_last              : result digit is the MSB digit of the word
//   cout                  : carry out of the word MSB (sub: 1 = no borrow)
//   frame_err             : one-cycle pulse on a framing violation
//   ovf                   : signed overflow of the word (DSA_OVF_FLAG_EN only)
//
// Configuration macro: DSA_OVF_FLAG_EN adds the ovf output and its logic.
// ---------------------------------------------------------------------------
module digit_serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int WORD_W  = DEF_WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] x_digit,
  input  logic [DIGIT_W-1:0] y_digit,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_last,
  output logic               cout,
`ifdef DSA_OVF_FLAG_EN
  output logic               ovf,
`endif
  output logic               frame_err
);

  localparam int NDIG  = WORD_W / DIGIT_W;
  localparam int CNT_W = $clog2(NDIG) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);
  localparam bit SINGLE = (NDIG == 1);

  if (WORD_W % DIGIT_W != 0) begin : g_bad_width
    $error("digit_serial_addsub: WORD_W must be a multiple of DIGIT_W");
  end

  dsa_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               sub_q, sub_d;

  logic               out_valid_q, out_valid_d;
  logic [DIGIT_W-1:0] out_digit_q, out_digit_d;
  logic               out_last_q, out_last_d;
  logic               cout_q, cout_d;
  logic               frame_err_q, frame_err_d;

  logic               start, cont, accept, is_last;
  logic               add_sub, add_cin;
  logic [DIGIT_W-1:0] y_eff, sum;
  logic               sum_cout;

  // A new word always wins, even mid-word; continuation digits only count
  // while a word is open.
  assign start   = in_valid & in_first;
  assign cont    = in_valid & ~in_first & (state_q == BUSY);
  assign accept  = start | cont;
  assign is_last = start ? SINGLE : (cnt_q == LAST_CNT);

  // Subtraction is X + ~Y + 1: the +1 enters as the first digit's carry-in.
  assign add_sub = start ? sub : sub_q;
  assign add_cin = start ? sub : carry_q;
  assign y_eff   = y_digit ^ {DIGIT_W{add_sub}};

`ifdef DSA_OVF_FLAG_EN
  logic msb_cin;
  logic ovf_q, ovf_d;
`else
  logic msb_cin_unused;
`endif

  digit_adder #(.W(DIGIT_W)) u_adder (
    .a       (x_digit),
    .b       (y_eff),
    .cin     (add_cin),
    .sum     (sum),
    .cout    (sum_cout),
`ifdef DSA_OVF_FLAG_EN
    .msb_cin (msb_cin)
`else
    .msb_cin (msb_cin_unused)
`endif
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    if (start) begin
      sub_d   = sub;
      carry_d = sum_cout;
      cnt_d   = CNT_W'(1);
      state_d = SINGLE ? IDLE : BUSY;
    end else if (cont) begin
      carry_d = sum_cout;
      if (is_last) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    out_valid_d = accept;
    out_digit_d = accept ? sum : '0;
    out_last_d  = accept & is_last;
    cout_d      = accept & is_last & sum_cout;
    // Restart while a word is open, or a continuation digit with none open.
    frame_err_d = in_valid & ((in_first & (state_q == BUSY)) |
                              (~in_first & (state_q == IDLE)));
`ifdef DSA_OVF_FLAG_EN
    ovf_d       = accept & is_last & (msb_cin ^ sum_cout);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_digit_q <= '0;
      out_last_q  <= 1'b0;
      cout_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef DSA_OVF_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      out_digit_q <= out_digit_d;
      out_last_q  <= out_last_d;
      cout_q      <= cout_d;
      frame_err_q <= frame_err_d;
`ifdef DSA_OVF_FLAG_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_digit = out_digit_q;
  assign out_last  = out_last_q;
  assign cout      = cout_q;
  assign frame_err = frame_err_q;
`ifdef DSA_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule : digit_serial_addsub

// File: tb/tb_digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_addsub
// Two instances: u=0 (DIGIT_W=1, WORD_W=8) and u=1 (DIGIT_W=4, WORD_W=32).
// A word-level model computes the full result, carry and signed overflow of
// each word with plain arithmetic; the expected per-cycle outputs are slices
// of that result. One compare process checks both instances every cycle.
// ---------------------------------------------------------------------------
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv[2], ifst[2], sb[2];
  logic [3:0] xd[2], yd[2];
  logic       x0, y0;
  logic       ov[2], ol[2], oc[2], fe[2];
  logic       od0;
  logic [3:0] od1;
`ifdef DSA_OVF_FLAG_EN
  logic       of[2];
`endif

  assign x0 = xd[0][0];
  assign y0 = yd[0][0];

  digit_serial_addsub #(.DIGIT_W(1), .WORD_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_first(ifst[0]), .sub(sb[0]),
    .x_digit(x0), .y_digit(y0), .out_valid(ov[0]), .out_digit(od0),
    .out_last(ol[0]), .cout(oc[0]),
`ifdef DSA_OVF_FLAG_EN
    .ovf(of[0]),
`endif
    .frame_err(fe[0])
  );

  digit_serial_addsub #(.DIGIT_W(4), .WORD_W(32)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_first(ifst[1]), .sub(sb[1]),
    .x_digit(xd[1]), .y_digit(yd[1]), .out_valid(ov[1]), .out_digit(od1),
    .out_last(ol[1]), .cout(oc[1]),
`ifdef DSA_OVF_FLAG_EN
    .ovf(of[1]),
`endif
    .frame_err(fe[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dw(int u); return (u == 0) ? 1 : 4; endfunction
  function automatic int ww(int u); return (u == 0) ? 8 : 32; endfunction
  function automatic int nd(int u); return ww(u) / dw(u); endfunction
  function automatic logic [31:0] wmask(int u);
    return (u == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [3:0] dig_of(logic [31:0] w, int u, int k);
    logic [31:0] m;
    m = (u == 0) ? 32'h1 : 32'hF;
    return 4'((w >> (k * dw(u))) & m);
  endfunction

  // ---- word-level model ----
  logic [31:0] wx[2], wy[2];
  logic        ws[2];
  logic [31:0] mword[2];
  logic        mcout[2], movf[2];
  bit          in_word[2];
  int          idx[2];

  task automatic model_start(int u);
    logic [32:0] x, y, r;
    logic        sx, sy, sr;
    x = {1'b0, wx[u] & wmask(u)};
    y = {1'b0, wy[u] & wmask(u)};
    if (ws[u]) begin
      r        = x - y;
      mcout[u] = (x >= y);
    end else begin
      r        = x + y;
      mcout[u] = (r > {1'b0, wmask(u)});
    end
    mword[u] = r[31:0] & wmask(u);
    sx = x[ww(u)-1];
    sy = y[ww(u)-1];
    sr = mword[u][ww(u)-1];
    movf[u] = ws[u] ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
  endtask

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
    logic       last;
    logic       cout;
    logic       ovf;
    logic       ferr;
  } exp_t;

  exp_t exp_next[2], exp_cur[2];
  bit   en_next = 1'b0, en_cur = 1'b0;
  logic rst_cur = 1'b0;

  always @(posedge clk) begin
    exp_cur <= exp_next;
    en_cur  <= en_next;
    rst_cur <= rst;
  end

  task automatic clear_inputs();
    for (int o = 0; o < 2; o++) begin
      iv[o] = 1'b0; ifst[o] = 1'b0; sb[o] = 1'b0; xd[o] = '0; yd[o] = '0;
      exp_next[o] = '0;
    end
  endtask

  // Drive one cycle on instance u (or idle) and record what must come out.
  task automatic tick(int u, bit v, bit f, int k);
    @(negedge clk);
    clear_inputs();
    en_next = 1'b1;
    if (!v) return;
    iv[u]   = 1'b1;
    ifst[u] = f;
    sb[u]   = f ? ws[u] : ~ws[u];   // sub must be ignored on non-first digits
    xd[u]   = dig_of(wx[u], u, k);
    yd[u]   = dig_of(wy[u], u, k);
    if (f) begin
      exp_next[u].ferr  = in_word[u];
      model_start(u);
      exp_next[u].valid = 1'b1;
      exp_next[u].digit = dig_of(mword[u], u, 0);
      if (nd(u) == 1) begin
        exp_next[u].last = 1'b1; exp_next[u].cout = mcout[u]; exp_next[u].ovf = movf[u];
      end
      in_word[u] = (nd(u) > 1);
      idx[u]     = 1;
    end else if (!in_word[u]) begin
      exp_next[u].ferr = 1'b1;
    end else begin
      exp_next[u].valid = 1'b1;
      exp_next[u].digit = dig_of(mword[u], u, idx[u]);
      if (idx[u] == nd(u) - 1) begin
        exp_next[u].last = 1'b1; exp_next[u].cout = mcout[u]; exp_next[u].ovf = movf[u];
        in_word[u] = 1'b0;
      end
      idx[u]++;
    end
  endtask

  task automatic idle(int n);
    repeat (n) tick(0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst     = 1'b1;
    iv[0]   = 1'b1;   // must be ignored during reset
    ifst[0] = 1'b1;
    en_next = 1'b1;
    in_word[0] = 1'b0; in_word[1] = 1'b0;
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic send_word(int u, logic [31:0] x, logic [31:0] y, logic s, int gap_max);
    wx[u] = x; wy[u] = y; ws[u] = s;
    for (int k = 0; k < nd(u); k++) begin
      repeat ($urandom_range(0, gap_max)) tick(u, 1'b0, 1'b0, 0);
      tick(u, 1'b1, (k == 0), k);
    end
    idle(2);
  endtask

  // ---- compare + result collector ----
  logic [31:0] acc[2], got_word[2];
  int          pos[2], last_cnt[2], ferr_cnt[2];
  logic        got_cout[2], got_ovf[2];

  initial begin
    for (int o = 0; o < 2; o++) begin
      acc[o] = '0; pos[o] = 0; last_cnt[o] = 0; ferr_cnt[o] = 0;
      got_word[o] = '0; got_cout[o] = 1'b0; got_ovf[o] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (en_cur) begin
      for (int u = 0; u < 2; u++) begin
        logic [3:0] ad;
        logic       aovf;
        ad = (u == 0) ? {3'b000, od0} : od1;
`ifdef DSA_OVF_FLAG_EN
        aovf = of[u];
`else
        aovf = 1'b0;
`endif
        check($sformatf("u%0d out_valid", u), 32'(ov[u]), 32'(exp_cur[u].valid));
        if (exp_cur[u].valid)
          check($sformatf("u%0d out_digit", u), 32'(ad), 32'(exp_cur[u].digit));
        check($sformatf("u%0d out_last", u), 32'(ol[u]), 32'(exp_cur[u].last));
        check($sformatf("u%0d cout", u), 32'(oc[u]), 32'(exp_cur[u].cout));
        check($sformatf("u%0d frame_err", u), 32'(fe[u]), 32'(exp_cur[u].ferr));
`ifdef DSA_OVF_FLAG_EN
        check($sformatf("u%0d ovf", u), 32'(of[u]), 32'(exp_cur[u].ovf));
`endif
        if (rst_cur || fe[u]) begin
          acc[u] = '0; pos[u] = 0;
        end
        if (fe[u]) ferr_cnt[u]++;
        if (ov[u]) begin
          acc[u] = acc[u] | (32'(ad) << (pos[u] * dw(u)));
          pos[u]++;
          if (ol[u]) begin
            got_word[u] = acc[u]; got_cout[u] = oc[u]; got_ovf[u] = aovf;
            last_cnt[u]++;
            acc[u] = '0; pos[u] = 0;
          end
        end
      end
    end
  end

  task automatic check_word(string name, int u, logic [31:0] w, logic c, logic v);
    check({name, " word"}, got_word[u], w);
    check({name, " cout"}, 32'(got_cout[u]), 32'(c));
`ifdef DSA_OVF_FLAG_EN
    check({name, " ovf"}, 32'(got_ovf[u]), 32'(v));
`else
    if (v === 1'bx) check({name, " ovf"}, 32'(got_ovf[u]), 32'(v));
`endif
  endtask

  initial begin
    int lc, fc;
    rst = 1'b1;
    clear_inputs();
    for (int o = 0; o < 2; o++) begin
      wx[o] = '0; wy[o] = '0; ws[o] = 1'b0; idx[o] = 0; in_word[o] = 1'b0;
      mword[o] = '0; mcout[o] = 1'b0; movf[o] = 1'b0;
    end
    repeat (2) @(negedge clk);
    do_reset();
    idle(1);

    // 0x35 + 0x4A = 0x7F, out_last on the 8th digit
    lc = last_cnt[0];
    send_word(0, 32'h35, 32'h4A, 1'b0, 0);
    check("model 35+4A", mword[0], 32'h7F);
    check("35+4A last count", 32'(last_cnt[0] - lc), 32'd1);
    check_word("35+4A", 0, 32'h7F, 1'b0, 1'b0);

    // 0x70 + 0x20 = 0x90, signed overflow
    send_word(0, 32'h70, 32'h20, 1'b0, 0);
    check("model 70+20 ovf", 32'(movf[0]), 32'd1);
    check_word("70+20", 0, 32'h90, 1'b0, 1'b1);

    // 0x80 - 0x01 = 0x7F, no borrow, overflow
    send_word(0, 32'h80, 32'h01, 1'b1, 1);
    check_word("80-01", 0, 32'h7F, 1'b1, 1'b1);

    // 0x10 - 0x20 on 32-bit/4-bit digits, then again with stalls
    send_word(1, 32'h10, 32'h20, 1'b1, 0);
    check("model 10-20", mword[1], 32'hFFFF_FFF0);
    check_word("10-20", 1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    got_word[1] = '0;
    send_word(1, 32'h10, 32'h20, 1'b1, 3);
    check_word("10-20 gaps", 1, 32'hFFFF_FFF0, 1'b0, 1'b0);

    // carry out of the word, then positive overflow
    send_word(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 2);
    check_word("FFFFFFFF+1", 1, 32'h0, 1'b1, 1'b0);
    send_word(1, 32'h7FFF_FFFF, 32'h1, 1'b0, 0);
    check_word("7FFFFFFF+1", 1, 32'h8000_0000, 1'b0, 1'b1);

    // mid-word restart on digit 3
    lc = last_cnt[0]; fc = ferr_cnt[0];
    wx[0] = 32'h55; wy[0] = 32'h0F; ws[0] = 1'b1;
    for (int k = 0; k < 3; k++) tick(0, 1'b1, (k == 0), k);
    send_word(0, 32'h01, 32'h01, 1'b0, 0);
    check("restart ferr count", 32'(ferr_cnt[0] - fc), 32'd1);
    check("restart last count", 32'(last_cnt[0] - lc), 32'd1);
    check_word("restart 01+01", 0, 32'h02, 1'b0, 1'b0);

    // reset mid-word, then a stray continuation digit
    lc = last_cnt[1]; fc = ferr_cnt[1];
    wx[1] = 32'h1234_5678; wy[1] = 32'h1; ws[1] = 1'b0;
    for (int k = 0; k < 3; k++) tick(1, 1'b1, (k == 0), k);
    do_reset();
    tick(1, 1'b1, 1'b0, 3);
    idle(2);
    check("post-reset stray ferr", 32'(ferr_cnt[1] - fc), 32'd1);
    check("post-reset no last", 32'(last_cnt[1] - lc), 32'd0);
    send_word(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1);
    check_word("post-reset word", 1, 32'h2345_6789, 1'b0, 1'b0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_digit_serial_addsub
